// File: rtl/led_runner_if.sv
// LED runner control/LED bundle. step_o/wrap_o exist only when
// LED_RUNNER_STEP_OUT_EN is defined.
interface led_runner_if #(parameter int NumLeds = 8);
  logic               enable_i;
  logic               sig_1hz_ni;
  logic [1:0]         mode_i;
  logic [NumLeds-1:0] leds_o;
`ifdef LED_RUNNER_STEP_OUT_EN
  logic               step_o;
  logic               wrap_o;

  modport master (output enable_i, sig_1hz_ni, mode_i, input leds_o, step_o, wrap_o);
  modport slave  (input enable_i, sig_1hz_ni, mode_i, output leds_o, step_o, wrap_o);
`else
  modport master (output enable_i, sig_1hz_ni, mode_i, input leds_o);
  modport slave  (input enable_i, sig_1hz_ni, mode_i, output leds_o);
`endif
endinterface

// File: rtl/led_runner.sv
// Running-light LED bar: one step per falling edge of the active-low 1 Hz tick.
// Optional step_o/wrap_o pulse outputs are built when LED_RUNNER_STEP_OUT_EN is defined.
module led_runner #(
  parameter  int NumLeds = 8,
  localparam int PosW    = $clog2(NumLeds + 1)
) (
  input logic         clk_i,
  input logic         rst_i,
  led_runner_if.slave bus
);
  typedef enum logic [1:0] {S_WRAP_L = 2'b00, S_WRAP_R = 2'b01, S_BOUNCE = 2'b10, S_FILL = 2'b11} state_t;

  localparam logic [PosW-1:0] LAST = PosW'(NumLeds - 1);
  localparam logic [PosW-1:0] FULL = PosW'(NumLeds);

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [PosW-1:0] pos_q, pos_d, level_q, level_d;
  logic            dir_up_q, dir_up_d;
  logic            sig_q;
  logic            step, reload, wrap;
  logic [NumLeds:0] shifted;

  assign step   = bus.enable_i & sig_q & ~bus.sig_1hz_ni;
  assign reload = step && (bus.mode_i != mode_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q    <= 1'b1;
      state_q  <= S_WRAP_L;
      mode_q   <= 2'b00;
      pos_q    <= '0;
      level_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      sig_q    <= bus.sig_1hz_ni;
      state_q  <= state_d;
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      level_q  <= level_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Reload (mode change) wins over advance and never counts as a wrap.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pos_d    = pos_q;
    level_d  = level_q;
    dir_up_d = dir_up_q;
    wrap     = 1'b0;
    if (reload) begin
      mode_d  = bus.mode_i;
      state_d = state_t'(bus.mode_i);
      case (state_t'(bus.mode_i))
        S_WRAP_L: pos_d = '0;
        S_WRAP_R: pos_d = LAST;
        S_BOUNCE: begin pos_d = '0; dir_up_d = 1'b1; end
        default:  level_d = PosW'(1);
      endcase
    end else if (step) begin
      case (state_q)
        S_WRAP_L: begin
          wrap  = (pos_q == LAST);
          pos_d = wrap ? '0 : pos_q + PosW'(1);
        end
        S_WRAP_R: begin
          wrap  = (pos_q == '0);
          pos_d = wrap ? LAST : pos_q - PosW'(1);
        end
        S_BOUNCE: begin
          if (dir_up_q) begin
            if (pos_q == LAST) begin dir_up_d = 1'b0; pos_d = LAST - PosW'(1); end
            else pos_d = pos_q + PosW'(1);
          end else begin
            if (pos_q == '0) begin dir_up_d = 1'b1; pos_d = PosW'(1); end
            else pos_d = pos_q - PosW'(1);
          end
          wrap = (pos_d == '0);
        end
        default: begin
          wrap    = (level_q == FULL);
          level_d = wrap ? '0 : level_q + PosW'(1);
        end
      endcase
    end
  end

  // Shift at NumLeds+1 bits so a full fill level yields all-ones after the -1.
  always_comb begin
    if (state_q == S_FILL) shifted = ((NumLeds+1)'(1) << level_q) - (NumLeds+1)'(1);
    else                   shifted = (NumLeds+1)'(1) << pos_q;
  end
  assign bus.leds_o = shifted[NumLeds-1:0];

`ifdef LED_RUNNER_STEP_OUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.step_o <= 1'b0;
      bus.wrap_o <= 1'b0;
    end else begin
      bus.step_o <= step;
      bus.wrap_o <= wrap;
    end
  end
`endif
endmodule

// File: tb/tb_led_runner.sv
// Self-checking bench for led_runner (NumLeds=8); expected patterns are queued
// when a tick is driven and popped when the new LED value is visible.
module tb_led_runner;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_runner_if #(.NumLeds(N)) bus ();
  led_runner #(.NumLeds(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {logic [N-1:0] leds; logic wrap;} exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;

`ifdef LED_RUNNER_STEP_OUT_EN
  always @(posedge clk) if (bus.step_o === 1'b1) step_cnt++;
`endif

  task automatic do_reset();
    bus.enable_i   = 1'b1;
    bus.sig_1hz_ni = 1'b1;
    bus.mode_i     = 2'b00;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Falls the tick and queues what leds_o must show one cycle later.
  task automatic tick_fall(input logic [N-1:0] leds, input logic wrap);
    exp_t e;
    e.leds = leds;
    e.wrap = wrap;
    @(negedge clk) bus.sig_1hz_ni = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic tick_rest();
    @(negedge clk) bus.sig_1hz_ni = 1'b1;
    repeat (17) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sig_1hz_ni = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.leds_o !== 8'h01) begin
      errors++; $display("FAIL reset_leds got=%h exp=01", bus.leds_o);
    end
`ifdef LED_RUNNER_STEP_OUT_EN
    checks++;
    if (bus.step_o !== 1'b0 || bus.wrap_o !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got step=%b wrap=%b exp=0/0", bus.step_o, bus.wrap_o);
    end
`endif
    do_reset();
  endtask

  task automatic test_wrap_left();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      tick_fall(8'(1 << (i % 8)), i == 8);
      e = exp_q.pop_front();
      checks++;
      if (bus.leds_o !== e.leds) begin
        errors++; $display("FAIL wrap_left[%0d] got=%h exp=%h", i, bus.leds_o, e.leds);
      end
`ifdef LED_RUNNER_STEP_OUT_EN
      checks++;
      if (bus.wrap_o !== e.wrap || bus.step_o !== 1'b1) begin
        errors++; $display("FAIL wrap_left_pulse[%0d] got wrap=%b step=%b exp wrap=%b step=1", i, bus.wrap_o, bus.step_o, e.wrap);
      end
`endif
      tick_rest();
    end
  endtask

  task automatic test_bounce();
    int bp[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    exp_t e;
    do_reset();
    bus.mode_i = 2'b10;
    for (int i = 0; i <= 15; i++) begin
      if (i == 0) tick_fall(8'h01, 1'b0);
      else        tick_fall(8'(1 << bp[i-1]), bp[i-1] == 0);
      e = exp_q.pop_front();
      checks++;
      if (bus.leds_o !== e.leds) begin
        errors++; $display("FAIL bounce[%0d] got=%h exp=%h", i, bus.leds_o, e.leds);
      end
`ifdef LED_RUNNER_STEP_OUT_EN
      checks++;
      if (bus.wrap_o !== e.wrap) begin
        errors++; $display("FAIL bounce_wrap[%0d] got=%b exp=%b", i, bus.wrap_o, e.wrap);
      end
`endif
      tick_rest();
    end
  endtask

  task automatic test_fill();
    logic [N-1:0] fseq[10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
    exp_t e;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      tick_fall(8'(1 << (i % 8)), i == 8);
      void'(exp_q.pop_front());
      tick_rest();
    end
    bus.mode_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick_fall(fseq[i], i == 8);
      e = exp_q.pop_front();
      checks++;
      if (bus.leds_o !== e.leds) begin
        errors++; $display("FAIL fill[%0d] got=%h exp=%h", i, bus.leds_o, e.leds);
      end
`ifdef LED_RUNNER_STEP_OUT_EN
      checks++;
      if (bus.wrap_o !== e.wrap) begin
        errors++; $display("FAIL fill_wrap[%0d] got=%b exp=%b", i, bus.wrap_o, e.wrap);
      end
`endif
      tick_rest();
    end
  endtask

  task automatic test_enable_and_hold();
    int s0;
    do_reset();
    s0 = step_cnt;
    bus.enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.sig_1hz_ni = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.leds_o !== 8'h01) begin
        errors++; $display("FAIL disabled[%0d] got=%h exp=01", i, bus.leds_o);
      end
      tick_rest();
    end
    bus.enable_i = 1'b1;
`ifdef LED_RUNNER_STEP_OUT_EN
    checks++;
    if (step_cnt !== s0) begin
      errors++; $display("FAIL disabled_steps got=%0d exp=%0d", step_cnt - s0, 0);
    end
`endif
    @(negedge clk) bus.sig_1hz_ni = 1'b0;
    repeat (50) @(negedge clk);
    bus.sig_1hz_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.leds_o !== 8'h02) begin
      errors++; $display("FAIL hold_low got=%h exp=02", bus.leds_o);
    end
`ifdef LED_RUNNER_STEP_OUT_EN
    checks++;
    if (step_cnt - s0 !== 1) begin
      errors++; $display("FAIL hold_low_steps got=%0d exp=1", step_cnt - s0);
    end
`endif
  endtask

  task automatic test_mode_change();
    exp_t e;
    do_reset();
    tick_fall(8'h02, 1'b0);
    void'(exp_q.pop_front());
    tick_rest();
    bus.mode_i = 2'b01;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.leds_o !== 8'h02) begin
      errors++; $display("FAIL mode_between_ticks got=%h exp=02", bus.leds_o);
    end
    tick_fall(8'h80, 1'b0);
    tick_rest();
    tick_fall(8'h40, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i == 0) begin
        // reload result was sampled before the rest; re-check its successor below
        continue;
      end
      checks++;
      if (bus.leds_o !== e.leds) begin
        errors++; $display("FAIL mode_next got=%h exp=%h", bus.leds_o, e.leds);
      end
    end
    tick_rest();
  endtask

  task automatic test_reload_wrap();
    exp_t e;
    do_reset();
    bus.mode_i = 2'b01;
    tick_fall(8'h80, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (bus.leds_o !== e.leds) begin
      errors++; $display("FAIL reload_r got=%h exp=%h", bus.leds_o, e.leds);
    end
`ifdef LED_RUNNER_STEP_OUT_EN
    checks++;
    if (bus.wrap_o !== 1'b0 || bus.step_o !== 1'b1) begin
      errors++; $display("FAIL reload_r_pulse got wrap=%b step=%b exp wrap=0 step=1", bus.wrap_o, bus.step_o);
    end
`endif
    tick_rest();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mode_i = 2'b10;
    tick_fall(8'h01, 1'b0);
    void'(exp_q.pop_front());
    tick_rest();
    for (int p = 1; p <= 9; p++) begin
      tick_fall(8'h00, 1'b0);
      void'(exp_q.pop_front());
      tick_rest();
    end
    checks++;
    if (bus.leds_o !== 8'h20) begin
      errors++; $display("FAIL mid_bounce_pos got=%h exp=20", bus.leds_o);
    end
    @(negedge clk) bus.sig_1hz_ni = 1'b0;
    bus.mode_i = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.leds_o !== 8'h01) begin
      errors++; $display("FAIL async_reset got=%h exp=01", bus.leds_o);
    end
    repeat (3) @(negedge clk);
    bus.sig_1hz_ni = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.leds_o !== 8'h01) begin
      errors++; $display("FAIL post_reset_idle got=%h exp=01", bus.leds_o);
    end
    tick_fall(8'h02, 1'b0);
    checks++;
    if (bus.leds_o !== exp_q[0].leds) begin
      errors++; $display("FAIL post_reset_step got=%h exp=%h", bus.leds_o, exp_q[0].leds);
    end
    void'(exp_q.pop_front());
    tick_rest();
  endtask

  initial begin
    bus.enable_i   = 1'b1;
    bus.sig_1hz_ni = 1'b1;
    bus.mode_i     = 2'b00;
    test_reset();
    test_wrap_left();
    test_bounce();
    test_fill();
    test_enable_and_hold();
    test_mode_change();
    test_reload_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
